// File: rtl/ga20_pkg.sv
// Shared types and constants for the GA20 sample-fetch path.
// Line geometry is fixed at 8 bytes, so a sample address splits into a 17-bit tag and a 3-bit byte offset.
package ga20_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fsm_t;

    localparam int LINE_BYTES = 8;
    localparam int TAG_W      = 17;

    // Little-endian byte pick: byte k sits in bits [8k+7:8k] of the line.
    function automatic logic [7:0] line_byte(input logic [63:0] line, input logic [2:0] k);
        return line[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/ga20_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after ptr_i, wrapping.
// It has no state of its own, so the owner decides when the pointer advances.
module ga20_rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int PW       = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [PW-1:0]       ptr_i,
    output logic [CHANNELS-1:0] gnt_o,
    output logic [PW-1:0]       idx_o
);

    always_comb begin : pick
        logic found;
        int   c;
        found = 1'b0;
        c     = 0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            c = (int'(ptr_i) + k) % CHANNELS;
            if (!found && req_i[c]) begin
                found    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = PW'(c);
            end
        end
    end

endmodule

// File: rtl/ga20_fetch_sched.sv
// Shares the single 64-bit sample-ROM SDRAM read port between the GA20 channels.
// Each channel has one 8-byte line; hits are answered locally, misses are filled one burst at a time.
module ga20_fetch_sched
    import ga20_pkg::*;
#(
    parameter int          CHANNELS = 4,
    parameter logic [24:0] SDR_BASE = 25'h0000000
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     inv,
    input  logic [CHANNELS-1:0]      ch_req,
    input  logic [20*CHANNELS-1:0]   ch_addr,
    output logic [CHANNELS-1:0]      ch_valid,
    output logic [8*CHANNELS-1:0]    ch_data,
    output logic [24:0]              sdr_addr,
    output logic                     sdr_req,
    input  logic [63:0]              sdr_data,
    input  logic                     sdr_rdy
);

    localparam int PW    = $clog2(CHANNELS);
    localparam int OFF_W = $clog2(LINE_BYTES);

    logic [19:0]          addr      [CHANNELS];
    logic [TAG_W-1:0]     tag_q     [CHANNELS];
    logic [63:0]          line_q    [CHANNELS];
    logic [7:0]           ch_data_q [CHANNELS];
    logic [7:0]           ch_data_d [CHANNELS];

    logic [CHANNELS-1:0]  lv_q, lv_d;
    logic [CHANNELS-1:0]  hit, pending;
    logic [CHANNELS-1:0]  arb_gnt;
    logic [PW-1:0]        arb_idx;
    logic [CHANNELS-1:0]  ch_valid_q, ch_valid_d;

    fsm_t                 fsm_q, fsm_d;
    logic [PW-1:0]        gnt_q, gnt_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [TAG_W-1:0]     gtag_q, gtag_d;
    logic [24:0]          sdr_addr_q, sdr_addr_d;
    logic                 sdr_req_q, sdr_req_d;
    logic                 poison_q, poison_d;
    logic                 fill_we, fill_en;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign addr[g]            = ch_addr[20*g +: 20];
        assign ch_data[8*g +: 8]  = ch_data_q[g];
    end

    assign ch_valid = ch_valid_q;
    assign sdr_addr = sdr_addr_q;
    assign sdr_req  = sdr_req_q;

    always_comb begin
        hit     = '0;
        pending = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i]     = ch_req[i] & lv_q[i] & (tag_q[i] == addr[i][19:OFF_W]);
            pending[i] = ch_req[i] & ~hit[i];
        end
    end

    ga20_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .PW       (PW)
    ) u_arb (
        .req_i (pending),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // Hit stage: inv in the same cycle suppresses the valid even though the line still matches.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            ch_valid_d[i] = hit[i] & ~inv;
            ch_data_d[i]  = hit[i] ? line_byte(line_q[i], addr[i][OFF_W-1:0]) : ch_data_q[i];
        end
    end

    assign fill_we = (fsm_q == WAIT) & sdr_rdy;

    always_comb begin
        fsm_d      = fsm_q;
        gnt_d      = gnt_q;
        gtag_d     = gtag_q;
        ptr_d      = ptr_q;
        sdr_req_d  = sdr_req_q;
        sdr_addr_d = sdr_addr_q;
        poison_d   = poison_q;
        fill_en    = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (|arb_gnt) begin
                    gnt_d      = arb_idx;
                    gtag_d     = addr[arb_idx][19:OFF_W];
                    sdr_addr_d = SDR_BASE + {5'b00000, addr[arb_idx][19:OFF_W], {OFF_W{1'b0}}};
                    sdr_req_d  = 1'b1;
                    poison_d   = 1'b0;
                    fsm_d      = WAIT;
                end
            end
            WAIT: begin
                if (inv) begin
                    poison_d = 1'b1;
                end
                if (sdr_rdy) begin
                    // A fill overlapped by an invalidate carries pre-reload data, so it never marks the line.
                    fill_en   = ~(poison_q | inv);
                    sdr_req_d = 1'b0;
                    poison_d  = 1'b0;
                    ptr_d     = (gnt_q == PW'(CHANNELS - 1)) ? '0 : gnt_q + 1'b1;
                    fsm_d     = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        lv_d = lv_q;
        if (fill_en) begin
            lv_d[gnt_q] = 1'b1;
        end
        if (inv) begin
            lv_d = '0;
        end
    end

    // Control and output register stage.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q      <= IDLE;
            gnt_q      <= '0;
            gtag_q     <= '0;
            ptr_q      <= '0;
            sdr_req_q  <= 1'b0;
            sdr_addr_q <= '0;
            poison_q   <= 1'b0;
            lv_q       <= '0;
            ch_valid_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                ch_data_q[i] <= '0;
            end
        end else begin
            fsm_q      <= fsm_d;
            gnt_q      <= gnt_d;
            gtag_q     <= gtag_d;
            ptr_q      <= ptr_d;
            sdr_req_q  <= sdr_req_d;
            sdr_addr_q <= sdr_addr_d;
            poison_q   <= poison_d;
            lv_q       <= lv_d;
            ch_valid_q <= ch_valid_d;
            for (int i = 0; i < CHANNELS; i++) begin
                ch_data_q[i] <= ch_data_d[i];
            end
        end
    end

    // Line storage is qualified by lv, so it needs no reset.
    always_ff @(posedge clk_sys) begin
        if (fill_we) begin
            line_q[gnt_q] <= sdr_data;
            tag_q[gnt_q]  <= gtag_q;
        end
    end

endmodule
